adc_serial_reader: RTL



---
 rtl/adc_reader_pkg.sv | 17 +
 rtl/adc_serial_reader_if.sv | 11 +
 rtl/adc_sclk_gen.sv | 61 ++++++
 rtl/adc_serial_reader.sv | 129 ++++++++++++
 4 files changed

// File: rtl/adc_reader_pkg.sv
// rtl/adc_reader_pkg.sv - shared state encoding and default geometry for the ADC serial reader
package adc_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_QUIET = 2'd3
   } state_t;

   localparam int DEF_CLK_DIV      = 4;
   localparam int DEF_FRAME_BITS   = 16;
   localparam int DEF_DATA_BITS    = 12;
   localparam int DEF_QUIET_CYCLES = 6;
   localparam int DEF_LEAD_BITS    = DEF_FRAME_BITS - DEF_DATA_BITS;

endpackage

// File: rtl/adc_serial_reader_if.sv
// rtl/adc_serial_reader_if.sv - ADC serial pin bundle (chip select, serial clock, data)
interface adc_serial_reader_if;

   logic adc_ncs;
   logic adc_sclk;
   logic adc_data;

   modport master (output adc_ncs, output adc_sclk, input adc_data);
   modport slave  (input adc_ncs, input adc_sclk, output adc_data);

endinterface

// File: rtl/adc_sclk_gen.sv
// rtl/adc_sclk_gen.sv - serial clock generator: half-period divider, edge strobes, bit counter
module adc_sclk_gen
   import adc_reader_pkg::*;
#(
   parameter int DIV  = DEF_CLK_DIV,
   parameter int BITS = DEF_FRAME_BITS
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_en,
   output logic                      o_sclk,
   output logic                      o_rise,
   output logic                      o_fall,
   output logic [$clog2(BITS+1)-1:0] o_bit_cnt
);

   localparam int HW = $clog2(DIV);
   localparam int BW = $clog2(BITS + 1);

   logic [HW-1:0] r_half_cnt;
   logic          r_sclk;
   logic [BW-1:0] r_bit_cnt;
   logic          w_toggle;
   logic          w_rise;
   logic          w_fall;
   logic          w_last;

   // Strobes mark the clock edge that is about to move SClk, so users can act on that same edge.
   assign w_toggle = i_en && (r_half_cnt == HW'(DIV - 1));
   assign w_rise   = w_toggle && !r_sclk;
   assign w_fall   = w_toggle && r_sclk;
   // Once every bit has had its rising edge, the end of the last high half stops SClk high.
   assign w_last   = w_fall && (r_bit_cnt == BW'(BITS));

   assign o_sclk    = r_sclk;
   assign o_rise    = w_rise;
   assign o_fall    = w_fall;
   assign o_bit_cnt = r_bit_cnt;

   // Divider, SClk level and count of rising edges; disabled means idle-high and cleared.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_half_cnt <= '0;
         r_sclk     <= 1'b1;
         r_bit_cnt  <= '0;
      end else if (!i_en || w_last) begin
         r_half_cnt <= '0;
         r_sclk     <= 1'b1;
         r_bit_cnt  <= '0;
      end else if (w_toggle) begin
         r_half_cnt <= '0;
         r_sclk     <= ~r_sclk;
         if (!r_sclk) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
      end else begin
         r_half_cnt <= r_half_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/adc_serial_reader.sv
// rtl/adc_serial_reader.sv - ADC serial master: one frame per start, strips lead bits, flags overruns
module adc_serial_reader
   import adc_reader_pkg::*;
#(
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int FRAME_BITS   = DEF_FRAME_BITS,
   parameter int DATA_BITS    = DEF_DATA_BITS,
   parameter int QUIET_CYCLES = DEF_QUIET_CYCLES
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   output logic                 o_busy,
   output logic                 o_overrun,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_frame_error,
   adc_serial_reader_if.master  adc
);

   localparam int LEAD_BITS = FRAME_BITS - DATA_BITS;
   localparam int QW        = $clog2(QUIET_CYCLES + 1);
   localparam int BW        = $clog2(FRAME_BITS + 1);

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_gen_en;
   logic                  w_sclk;
   logic                  w_rise;
   logic                  w_fall;
   logic                  w_last;
   logic [BW-1:0]         w_bit_cnt;
   logic [FRAME_BITS-1:0] r_shift;
   logic [QW-1:0]         r_quiet_cnt;
   logic                  r_ncs;
   logic                  r_busy;
   logic                  r_overrun;
   logic                  r_valid;
   logic                  r_frame_error;
   logic [DATA_BITS-1:0]  r_data;

   // SETUP is simply the first high half-period, so the generator runs through SETUP and SHIFT.
   assign w_gen_en = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
   assign w_last   = (r_state == ST_SHIFT) && w_fall && (w_bit_cnt == BW'(FRAME_BITS));

   adc_sclk_gen #(
      .DIV  (CLK_DIV),
      .BITS (FRAME_BITS)
   ) u_sclk_gen (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (w_gen_en),
      .o_sclk    (w_sclk),
      .o_rise    (w_rise),
      .o_fall    (w_fall),
      .o_bit_cnt (w_bit_cnt)
   );

   // Next-state selection for the conversion sequence.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (i_start) w_next_state = ST_SETUP;
         ST_SETUP: if (w_fall) w_next_state = ST_SHIFT;
         ST_SHIFT: if (w_last) w_next_state = ST_QUIET;
         ST_QUIET: if (r_quiet_cnt == QW'(QUIET_CYCLES - 1)) w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Quiet-time counter, restarted on every entry to QUIET.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_quiet_cnt <= '0;
      end else if (r_state == ST_QUIET) begin
         r_quiet_cnt <= r_quiet_cnt + 1'b1;
      end else begin
         r_quiet_cnt <= '0;
      end
   end

   // Capture the pin value present just before the edge that raises SClk, MSB first.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift <= '0;
      end else if (w_rise) begin
         r_shift <= {r_shift[FRAME_BITS-2:0], adc.adc_data};
      end
   end

   // Registered outputs, derived from the next state so chip select and busy line up with it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ncs         <= 1'b1;
         r_busy        <= 1'b0;
         r_overrun     <= 1'b0;
         r_valid       <= 1'b0;
         r_frame_error <= 1'b0;
         r_data        <= '0;
      end else begin
         r_ncs     <= !((w_next_state == ST_SETUP) || (w_next_state == ST_SHIFT));
         r_busy    <= (w_next_state != ST_IDLE);
         r_overrun <= i_start && (r_state != ST_IDLE);
         r_valid   <= w_last;
         if (w_last) begin
            r_data        <= r_shift[DATA_BITS-1:0];
            r_frame_error <= |r_shift[FRAME_BITS-1:FRAME_BITS-LEAD_BITS];
         end
      end
   end

   assign adc.adc_ncs   = r_ncs;
   assign adc.adc_sclk  = w_sclk;
   assign o_busy        = r_busy;
   assign o_overrun     = r_overrun;
   assign o_valid       = r_valid;
   assign o_frame_error = r_frame_error;
   assign o_data        = r_data;

endmodule
